// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample/frame widths, bit-index width and the frame payload type.
package i2s_pkg;

  localparam int unsigned SAMPLE_W       = 24;
  localparam int unsigned FRAME_W        = 48;
  localparam int unsigned BITS_PER_FRAME = 48;
  localparam int unsigned BIT_IDX_W      = 6;

  // One stereo frame as written by the host: left sample in the upper half.
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;

endpackage

// File: rtl/i2s_fifo.sv
// Synchronous frame FIFO with registered full/empty flags and show-ahead read data.
// Ports:
//   clk_soc, reset_n   clock, async active-low reset (empties the FIFO)
//   wr_en, wr_data     enqueue request and frame; ignored while full
//   rd_en              pop request; ignored while empty
//   rd_data            frame at the head of the queue (valid while !empty)
//   full, empty        registered occupancy flags
module i2s_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic   clk_soc,
  input  logic   reset_n,
  input  logic   wr_en,
  input  frame_t wr_data,
  input  logic   rd_en,
  output frame_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_wr, do_rd;

  frame_t mem_q [FIFO_DEPTH];

  // Pointer/count update; a write on a full FIFO is dropped even if a pop happens the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_wr    = wr_en & ~full_q;
    do_rd    = rd_en & ~empty_q;

    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);

    if (do_wr && !do_rd)      count_d = count_q + CW'(1);
    else if (do_rd && !do_wr) count_d = count_q - CW'(1);

    full_d  = (count_d == CW'(FIFO_DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_soc or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk_soc) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/i2s_master.sv
// I2S transmitter master: buffers 48-bit stereo frames and serialises them
// MSB first with no one-bit delay (Philips timing without the delay slot).
// Ports:
//   clk_soc, reset_n   clock, async active-low reset
//   frame_in           frame to enqueue ([47:24] left, [23:0] right)
//   write_frame        enqueue strobe
//   full               FIFO holds FIFO_DEPTH frames (registered)
//   bclk, lrclk, sdata serial bit clock, word select (0 = left), data
module i2s_master
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic               clk_soc,
  input  logic               reset_n,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               write_frame,
  output logic               full,
  output logic               bclk,
  output logic               lrclk,
  output logic               sdata
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LAST_BIT = BITS_PER_FRAME - 1;

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 bclk_q, bclk_d;
  logic                 lrclk_q, lrclk_d;
  logic                 sdata_q, sdata_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;

  logic                 tick;
  logic                 rise;
  logic                 frame_start;
  logic                 pop;
  logic [BIT_IDX_W-1:0] bit_nxt;
  logic [FRAME_W-1:0]   load;
  frame_t               fifo_rd;
  logic                 fifo_empty;
  logic                 fifo_full;

  i2s_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_soc (clk_soc),
    .reset_n (reset_n),
    .wr_en   (write_frame),
    .wr_data (frame_t'(frame_in)),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Divider, bit counter and serializer; lrclk/sdata only move on the cycle bclk rises.
  always_comb begin
    div_d     = div_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    load      = '0;

    tick        = (div_q == DIV_W'(CLK_DIV - 1));
    rise        = tick & ~bclk_q;
    bit_nxt     = (bit_idx_q == BIT_IDX_W'(LAST_BIT)) ? '0 : bit_idx_q + BIT_IDX_W'(1);
    frame_start = rise & (bit_nxt == '0);
    pop         = frame_start & ~fifo_empty;

    div_d = tick ? '0 : div_q + DIV_W'(1);
    if (tick) bclk_d = ~bclk_q;

    if (rise) begin
      bit_idx_d = bit_nxt;
      lrclk_d   = (bit_nxt >= BIT_IDX_W'(SAMPLE_W));
      if (frame_start) begin
        // An empty FIFO yields a silent frame; timing is unchanged.
        if (pop) load = fifo_rd;
        sdata_d = load[FRAME_W-1];
        shift_d = {load[FRAME_W-2:0], 1'b0};
      end else begin
        sdata_d = shift_q[FRAME_W-1];
        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
      end
    end
  end

  // Reset parks the index on the last left bit of a silent frame so the
  // first bclk rise starts a right half and the first frame start follows 24 bits later.
  always_ff @(posedge clk_soc or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b1;
      sdata_q   <= 1'b0;
      bit_idx_q <= BIT_IDX_W'(SAMPLE_W - 1);
      shift_q   <= '0;
    end else begin
      div_q     <= div_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign full  = fifo_full;
  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;
  assign sdata = sdata_q;

endmodule

// File: tb/tb_i2s_master.sv
// Bench for i2s_master: a cycle-level timing/queue model checked every cycle,
// a bclk-falling-edge receiver, and directed scenarios with literal expectations.
module tb_i2s_master;

  localparam int CLK_DIV = 25;
  localparam int DEPTH   = 16;
  localparam int PER     = 2 * CLK_DIV;

  logic        clk_soc     = 1'b0;
  logic        reset_n     = 1'b0;
  logic        write_frame = 1'b0;
  logic [47:0] frame_in    = '0;
  logic        full, bclk, lrclk, sdata;

  int total = 0;
  int bad   = 0;

  i2s_master #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_soc     (clk_soc),
    .reset_n     (reset_n),
    .frame_in    (frame_in),
    .write_frame (write_frame),
    .full        (full),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata)
  );

  always #5 clk_soc = ~clk_soc;

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // n = clk edges since reset release; r = bclk rises so far.
  // Rise r>=1 drives position (r+23) mod 48; frame j starts at rise 25+48j.
  int          n = 0;
  int          r = 0;
  logic [47:0] mq[$];
  logic [47:0] cur = '0;
  logic        exp_bclk = 1'b0, exp_lr = 1'b1, exp_sd = 1'b0, exp_full = 1'b0;
  bit          full_before;

  always @(posedge clk_soc) begin
    if (!reset_n) begin
      n = 0; r = 0; mq.delete(); cur = '0;
      exp_bclk = 1'b0; exp_lr = 1'b1; exp_sd = 1'b0; exp_full = 1'b0;
    end else begin
      full_before = (mq.size() == DEPTH);
      n++;
      r = (n + CLK_DIV) / PER;
      if (((n + CLK_DIV) % PER) == 0 && r >= 25 && ((r - 25) % 48) == 0)
        cur = (mq.size() > 0) ? mq.pop_front() : 48'h0;
      if (write_frame && !full_before) mq.push_back(frame_in);
      exp_full = (mq.size() == DEPTH);
      exp_bclk = ((n / CLK_DIV) % 2) == 1;
      exp_lr   = (r == 0) ? 1'b1 : (((r + 23) % 48) >= 24);
      exp_sd   = (r < 25) ? 1'b0 : cur[47 - ((r - 25) % 48)];
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_soc) begin
    if (reset_n) begin
      check("bclk",  48'(bclk),  48'(exp_bclk));
      check("lrclk", 48'(lrclk), 48'(exp_lr));
      check("sdata", 48'(sdata), 48'(exp_sd));
      check("full",  48'(full),  48'(exp_full));
    end
  end

  // ---------------- receiver ----------------
  logic        prev_bclk = 1'b0, prev_lr = 1'b1, have_left = 1'b0;
  bit          gap_valid = 1'b0;
  int          half_cnt = 0, gap = 0;
  logic [23:0] lw = '0, rw = '0;
  logic [47:0] rxq[$];

  always @(negedge clk_soc) begin
    if (!reset_n) begin
      prev_bclk = 1'b0; prev_lr = 1'b1; have_left = 1'b0;
      gap_valid = 1'b0; half_cnt = 0; gap = 0;
      rxq.delete();
    end else begin
      gap++;
      if (bclk && !prev_bclk) begin
        if (gap_valid) check("bclk_period", 48'(gap), 48'(PER));
        gap_valid = 1'b1;
        gap = 0;
      end
      if (!bclk && prev_bclk) begin
        if (lrclk != prev_lr) begin
          check("half_bits", 48'(half_cnt), 48'(24));
          if (prev_lr && !lrclk) begin
            if (have_left) rxq.push_back({lw, rw});
            have_left = 1'b0;
          end else begin
            have_left = 1'b1;
          end
          half_cnt = 0;
        end
        if (!lrclk) lw = {lw[22:0], sdata};
        else        rw = {rw[22:0], sdata};
        half_cnt++;
        prev_lr = lrclk;
      end
      prev_bclk = bclk;
    end
  end

  function automatic logic [47:0] rx_at(input int i);
    if (i < rxq.size()) return rxq[i];
    return 'x;
  endfunction

  task automatic wait_rx(input int cnt, input int budget, input string name);
    int k = 0;
    while (rxq.size() < cnt && k < budget) begin
      @(negedge clk_soc);
      k++;
    end
    check(name, 48'(rxq.size() >= cnt), 48'(1));
  endtask

  // Async reset in mid-cycle; outputs must take reset values at once.
  task automatic apply_reset();
    @(negedge clk_soc);
    #1 reset_n = 1'b0;
    write_frame = 1'b0;
    #1;
    check("rst_bclk",  48'(bclk),  48'(0));
    check("rst_lrclk", 48'(lrclk), 48'(1));
    check("rst_sdata", 48'(sdata), 48'(0));
    check("rst_full",  48'(full),  48'(0));
    repeat (3) @(negedge clk_soc);
    reset_n = 1'b1;
  endtask

  task automatic write_one(input logic [47:0] v);
    frame_in    = v;
    write_frame = 1'b1;
    @(negedge clk_soc);
    write_frame = 1'b0;
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: bench did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] vec [4];
    int cnt;
    vec[0] = 48'h123456_abcdef;
    vec[1] = 48'h111111_222222;
    vec[2] = 48'h333333_444444;
    vec[3] = 48'h555555_666666;

    // Four back-to-back frames, then a silent fifth frame.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      frame_in    = vec[i];
      write_frame = 1'b1;
      @(negedge clk_soc);
    end
    write_frame = 1'b0;
    wait_rx(5, 20000, "wait_first5");
    for (int i = 0; i < 4; i++) check($sformatf("frame%0d", i), rx_at(i), vec[i]);
    check("frame4_zero", rx_at(4), 48'h0);

    // Write while a frame is on the wire: lands in the following frame.
    write_one(48'habcdef_fedcba);
    wait_rx(6, 5000, "wait_x");
    repeat (600) @(negedge clk_soc);
    write_one(48'ha5a5a5_5a5a5a);
    wait_rx(8, 8000, "wait_y");
    check("frame5_zero", rx_at(5), 48'h0);
    check("frame_x",     rx_at(6), 48'habcdef_fedcba);
    check("frame_y",     rx_at(7), 48'ha5a5a5_5a5a5a);

    // Fill to full with continuous writes; further writes are dropped.
    apply_reset();
    frame_in    = 48'hffffff_ffffff;
    write_frame = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk_soc);
      cnt++;
    end while (!full && cnt < 10000);
    check("writes_to_full", 48'(cnt), 48'(16));
    frame_in = 48'h171717_171717;
    repeat (3) @(negedge clk_soc);
    check("full_held", 48'(full), 48'(1));
    write_frame = 1'b0;
    wait_rx(1, 6000, "wait_ff");
    check("frame_ff", rx_at(0), 48'hffffff_ffffff);

    // Reset mid-frame with many frames queued; afterwards only silence.
    repeat (300) @(negedge clk_soc);
    apply_reset();
    @(negedge clk_soc);
    check("full_after_rst", 48'(full), 48'(0));
    wait_rx(2, 8000, "wait_post_rst");
    check("post_rst0", rx_at(0), 48'h0);
    check("post_rst1", rx_at(1), 48'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
